// File: rtl/aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_seq
// Description : Sequential AES-128/192/256 key schedule, streams w[i] over a
//               valid/ready port. Optional last-key capture: KEYEXP_LAST_KEY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand_seq #(
    parameter int SBOX_LANES = 4,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [255:0]     key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [31:0]      rk_word,
    output logic [IDX_W-1:0] rk_idx,
    output logic             done,
    output logic             cfg_err
`ifdef KEYEXP_LAST_KEY_EN
    ,
    output logic [255:0]     last_key,
    output logic             last_key_vld
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_SUB  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] c_SUB_LAST = 2'(4 / SBOX_LANES - 1);

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (product of a^2 .. a^128); maps 0 to 0.
    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = f_gmul(sq, sq);
            r  = f_gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Window offset of w[i+1-Nk] when w[i] sits in slot 7 (8 - Nk).
    function automatic logic [2:0] f_off(input logic [1:0] kl);
        case (kl)
            2'b01:   return 3'd2;
            2'b10:   return 3'd0;
            default: return 3'd4;
        endcase
    endfunction

    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [1:0]       r_klen;
    logic [31:0]      r_win [8];
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_pos;
    logic [7:0]       r_rcon;
    logic [3:0][7:0]  r_tmp;
    logic             r_rot;
    logic [1:0]       r_scnt;
    logic             r_done;
    logic             r_cfg_err;

    logic [2:0]       w_off;
    logic [2:0]       w_off_in;
    logic [3:0]       w_nk;
    logic             w_nk8;
    logic [IDX_W-1:0] w_last_idx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [2:0]       w_pos_nx;
    logic [2:0]       w_lsel;
    logic             w_hs;
    logic             w_is_last;
    logic             w_in_key;
    logic             w_need_sub;
    logic             w_go_sub;
    logic             w_go_lin;
    logic             w_sub_end;
    logic             w_accept;
    logic [31:0]      w_new;
    logic [3:0][7:0]  w_tmp_sub;
    logic [7:0][31:0] w_kw;
    logic [31:0]      w_key_win [8];
    logic [1:0]       w_bp  [SBOX_LANES];
    logic [7:0]       w_sbo [SBOX_LANES];

    assign w_off      = f_off(r_klen);
    assign w_off_in   = f_off(key_len);
    assign w_nk       = 4'd8 - {1'b0, w_off};
    assign w_nk8      = (w_off == 3'd0);
    assign w_hs       = rk_valid & rk_ready;
    assign w_idx_nx   = r_idx + IDX_W'(1);
    assign w_pos_nx   = (r_pos == 3'(w_nk - 4'd1)) ? 3'd0 : r_pos + 3'd1;
    assign w_is_last  = (r_idx == w_last_idx);
    assign w_in_key   = (w_idx_nx < IDX_W'(w_nk));
    assign w_need_sub = (w_pos_nx == 3'd0) | (w_nk8 & (w_pos_nx == 3'd4));
    assign w_go_sub   = w_hs & ~w_is_last & ~w_in_key & w_need_sub;
    assign w_go_lin   = w_hs & ~w_is_last & ~w_in_key & ~w_need_sub;
    assign w_sub_end  = (r_state == S_SUB) && (r_scnt == c_SUB_LAST);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_lsel     = w_off + r_idx[2:0];
    assign w_kw       = key_in;

    always_comb begin
        case (r_klen)
            2'b01:   w_last_idx = IDX_W'(51);
            2'b10:   w_last_idx = IDX_W'(59);
            default: w_last_idx = IDX_W'(43);
        endcase
    end

    // Key words are right-aligned in the window so slot 7 holds w[Nk-1].
    always_comb begin
        logic [2:0] w_src;
        for (int j = 0; j < 8; j++) begin
            w_src        = 3'(j) - w_off_in;
            w_key_win[j] = (3'(j) >= w_off_in) ? w_kw[~w_src] : 32'h0;
        end
    end

    for (genvar gl = 0; gl < SBOX_LANES; gl++) begin : g_lane
        assign w_bp[gl]  = 2'(int'(r_scnt) * SBOX_LANES + gl);
        assign w_sbo[gl] = f_sbox(r_tmp[~w_bp[gl]]);
    end

    always_comb begin
        w_tmp_sub = r_tmp;
        for (int l = 0; l < SBOX_LANES; l++) begin
            w_tmp_sub[~w_bp[l]] = w_sbo[l];
        end
    end

    always_comb begin
        w_new = r_win[w_off] ^ r_win[7];
        if (r_state == S_SUB) begin
            w_new = r_win[w_off] ^ w_tmp_sub ^ (r_rot ? {r_rcon, 24'h0} : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nx = S_LOAD;
            S_LOAD, S_EMIT: begin
                if (w_hs) begin
                    if (w_is_last)       w_state_nx = S_DONE;
                    else if (w_in_key)   w_state_nx = S_LOAD;
                    else if (w_need_sub) w_state_nx = S_SUB;
                    else                 w_state_nx = S_EMIT;
                end
            end
            S_SUB:   if (r_scnt == c_SUB_LAST) w_state_nx = S_EMIT;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_LOAD) || (r_state == S_EMIT) ||
                   (r_state == S_SUB)  || (r_state == S_DONE);
        rk_valid = (r_state == S_LOAD) || (r_state == S_EMIT);
        rk_word  = (r_state == S_LOAD) ? r_win[w_lsel] : r_win[7];
        rk_idx   = r_idx;
        done     = r_done;
        cfg_err  = r_cfg_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) r_win[k] <= '0;
            r_klen    <= '0;
            r_idx     <= '0;
            r_pos     <= '0;
            r_rcon    <= '0;
            r_tmp     <= '0;
            r_rot     <= 1'b0;
            r_scnt    <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= (r_state == S_DONE);
            r_cfg_err <= w_accept && (key_len == 2'b11);
            if (w_accept) begin
                for (int k = 0; k < 8; k++) r_win[k] <= w_key_win[k];
                r_klen <= (key_len == 2'b11) ? 2'b00 : key_len;
                r_idx  <= '0;
                r_pos  <= '0;
                r_rcon <= 8'h01;
                r_scnt <= '0;
            end else begin
                if (w_hs && !w_is_last) begin
                    r_idx <= w_idx_nx;
                    r_pos <= w_pos_nx;
                end
                if (w_go_sub) begin
                    r_tmp  <= (w_pos_nx == 3'd0) ? {rk_word[23:0], rk_word[31:24]} : rk_word;
                    r_rot  <= (w_pos_nx == 3'd0);
                    r_scnt <= '0;
                end
                if ((r_state == S_SUB) && !w_sub_end) begin
                    r_tmp  <= w_tmp_sub;
                    r_scnt <= r_scnt + 2'd1;
                end
                if (w_sub_end && r_rot) r_rcon <= f_xtime(r_rcon);
                if (w_go_lin || w_sub_end) begin
                    for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
                    r_win[7] <= w_new;
                end
            end
        end
    end

`ifdef KEYEXP_LAST_KEY_EN
    logic [7:0][31:0] w_lk;
    logic [255:0]     r_last_key;
    logic             r_last_vld;

    // The window's top Nk slots hold the final round-key words at completion.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_lk[~3'(j)] = (j < int'(w_nk)) ? r_win[3'(j) + w_off] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_key <= '0;
            r_last_vld <= 1'b0;
        end else if (w_accept) begin
            r_last_vld <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_last_key <= w_lk;
            r_last_vld <= 1'b1;
        end
    end

    assign last_key     = r_last_key;
    assign last_key_vld = r_last_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand_seq
// Description : Scoreboard bench for aes_key_expand_seq against a FIPS-197
//               style key-expansion model with random keys and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand_seq;

    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         rk_ready;
    wire          busy;
    wire          rk_valid;
    wire  [31:0]  rk_word;
    wire  [5:0]   rk_idx;
    wire          done;
    wire          cfg_err;
`ifdef KEYEXP_LAST_KEY_EN
    wire  [255:0] last_key;
    wire          last_key_vld;
`endif

    aes_key_expand_seq #(.SBOX_LANES(LANES), .IDX_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_word  (rk_word),
        .rk_idx   (rk_idx),
        .done     (done),
        .cfg_err  (cfg_err)
`ifdef KEYEXP_LAST_KEY_EN
        ,
        .last_key     (last_key),
        .last_key_vld (last_key_vld)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] word;
        int          gap;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad   = 0;
    bit           rand_rdy = 1'b0;
    logic [7:0]   sbox_t [256];
    logic [31:0]  m_w [60];
    logic [31:0]  obs [64];
    logic [255:0] exp_lk;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // Polynomial product then reduction by 11B.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) for (int b = 1; b < 256; b++) if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int nk, input int tot);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) m_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    // Pushes the expected stream, pulses start for one cycle from the current time.
    task automatic launch(input logic [255:0] key, input logic [1:0] kl);
        int   nk;
        int   tot;
        exp_t e;
        nk  = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
        tot = 4 * (nk + 7);
        model_expand(key, nk, tot);
        for (int i = 0; i < tot; i++) begin
            e.idx  = i;
            e.word = m_w[i];
            e.gap  = (i >= nk && (i % nk == 0 || (nk == 8 && i % nk == 4))) ? 4 / LANES : 0;
            q.push_back(e);
        end
        exp_lk = '0;
        for (int j = 0; j < nk; j++) exp_lk[255-32*j -: 32] = m_w[tot-nk+j];
        for (int i = 0; i < 64; i++) obs[i] = 32'h0;
        start   = 1'b1;
        key_len = kl;
        key_in  = key;
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_len = 2'($urandom_range(0, 3));
        check("busy_rise", busy, 1'b1);
        check("first_word", {rk_valid, 26'h0, rk_idx, rk_word}, {1'b1, 26'h0, 6'd0, m_w[0]});
        check("cfg_err_pulse", cfg_err, (kl == 2'b11));
`ifdef KEYEXP_LAST_KEY_EN
        check("last_vld_clear", last_key_vld, 1'b0);
`endif
        @(posedge clk); #1;
        check("cfg_err_end", cfg_err, 1'b0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1'b1);
        if (seen) begin
            check("busy_at_done", busy, 1'b0);
            check("words_left", q.size(), 0);
`ifdef KEYEXP_LAST_KEY_EN
            check("last_key_vld", last_key_vld, 1'b1);
            check("last_key", last_key, exp_lk);
`endif
        end
        q.delete();
    endtask

    task automatic idle_end();
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stall stability and bubbles.
    initial begin
        int          gap;
        bit          pstall;
        logic [31:0] pw;
        logic [5:0]  pi;
        exp_t        e;
        gap    = 0;
        pstall = 1'b0;
        pw     = '0;
        pi     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap    = 0;
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    total++;
                    if (!(rk_valid && rk_word == pw && rk_idx == pi)) begin
                        bad++;
                        $display("FAIL stall_hold: got v=%0b idx=%0d w=%h want idx=%0d w=%h",
                                 rk_valid, rk_idx, rk_word, pi, pw);
                    end
                end
                if (busy && !rk_valid) gap++;
                if (!busy) gap = 0;
                if (rk_valid && rk_ready) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_word: got idx=%0d w=%h want none", rk_idx, rk_word);
                    end else begin
                        e = q.pop_front();
                        if (rk_idx != 6'(e.idx) || rk_word !== e.word) begin
                            bad++;
                            $display("FAIL word: got idx=%0d w=%h want idx=%0d w=%h",
                                     rk_idx, rk_word, e.idx, e.word);
                        end
                        total++;
                        if (gap != e.gap) begin
                            bad++;
                            $display("FAIL bubble idx %0d: got %0d want %0d", e.idx, gap, e.gap);
                        end
                    end
                    obs[rk_idx] = rk_word;
                    gap = 0;
                end
                pstall = rk_valid && !rk_ready;
                pw     = rk_word;
                pi     = rk_idx;
            end
        end
    end

    initial begin
        bit found;
        rst_n   = 1'b0;
        start   = 1'b0;
        key_len = 2'b00;
        key_in  = '0;
        build_sbox();
        #12;
        check("rst_outputs", {busy, rk_valid, rk_word, rk_idx, done, cfg_err}, '0);
`ifdef KEYEXP_LAST_KEY_EN
        check("rst_last_key", {last_key_vld, last_key}, '0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        launch(K128, 2'b00);
        wait_done();
        check("a1_w4", obs[4], 32'ha0fafe17);
        check("a1_w43", obs[43], 32'hb6630ca6);
        idle_end();

        launch(K192, 2'b01);
        wait_done();
        check("a2_w6", obs[6], 32'hfe0c91f7);
        check("a2_w51", obs[51], 32'h01002202);
        idle_end();

        launch(K256, 2'b10);
        wait_done();
        check("a3_w8", obs[8], 32'h9ba35411);
        check("a3_w59", obs[59], 32'h706c631e);
        idle_end();

        // Backpressure plus a start pulse that must be ignored while busy.
        rand_rdy = 1'b1;
        launch(K128, 2'b00);
        repeat (4) begin @(posedge clk); #1; end
        start   = 1'b1;
        key_in  = K256;
        key_len = 2'b10;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check("stall_a1_w43", obs[43], 32'hb6630ca6);
        idle_end();

        rand_rdy = 1'b0;
        launch(K128, 2'b11);
        wait_done();
        check("illegal_w43", obs[43], 32'hb6630ca6);
`ifdef KEYEXP_LAST_KEY_EN
        check("illegal_last_key", last_key[255:128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
        idle_end();

        rand_rdy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            launch({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   2'(r % 3));
            wait_done();
            idle_end();
        end

        // Back-to-back: start raised in the cycle done is high.
        launch(K256, 2'b10);
        wait_done();
        launch(K192, 2'b01);
        wait_done();
        check("b2b_a2_w51", obs[51], 32'h01002202);
        idle_end();

        // Reset mid-run at index 20.
        rand_rdy = 1'b0;
        launch(K128, 2'b00);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (rk_valid && rk_idx == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_idx20", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_outputs", {busy, rk_valid, rk_word, rk_idx, done, cfg_err}, '0);
        q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", {done, busy}, 2'b00);
        end
        launch(K128, 2'b00);
        wait_done();
        check("post_rst_w0", obs[0], 32'h2b7e1516);
        check("post_rst_w43", obs[43], 32'hb6630ca6);
        idle_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
